// File: rtl/vram_arbiter.sv
// Time-slot arbiter sharing the gfx and text video RAMs between display scanout and a CPU port.
// Define VRAM_ARB_WBUF_EN to add a single-entry posted write buffer for CPU writes.
module vram_arbiter #(
  parameter int GFX_AW     = 16,
  parameter int TXT_AW     = 10,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_en,
  input  logic [GFX_AW-1:0] disp_gfx_addr,
  input  logic [TXT_AW-1:0] disp_txt_addr,
  output logic [DW-1:0]     disp_gfx_data,
  output logic [DW-1:0]     disp_txt_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_sel,
  input  logic [GFX_AW-1:0] cpu_addr,
  input  logic [DW-1:0]     cpu_wdata,
  output logic              cpu_ack,
  output logic [DW-1:0]     cpu_rdata,
  output logic [GFX_AW-1:0] gfx_addr,
  output logic              gfx_we,
  output logic [DW-1:0]     gfx_wdata,
  input  logic [DW-1:0]     gfx_rdata,
  output logic [TXT_AW-1:0] txt_addr,
  output logic              txt_we,
  output logic [DW-1:0]     txt_wdata,
  input  logic [DW-1:0]     txt_rdata
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RDWAIT, S_ACK} state_t;
  state_t state_reg, state_next;

  // Index 0 is the gfx RAM, index 1 the text RAM (matches cpu_sel).
  logic [1:0]        need, cpu_want, disp_win, cpu_win;
  logic [1:0]        fetch_reg, last_valid_reg;
  logic [SW-1:0]     starve_reg [2];
  logic [GFX_AW-1:0] gfx_last_reg;
  logic [TXT_AW-1:0] txt_last_reg;
  logic [GFX_AW-1:0] acc_addr;
  logic              acc_we;
  logic [DW-1:0]     acc_wdata;

  assign need[0] = !rst && disp_en && (!last_valid_reg[0] || disp_gfx_addr != gfx_last_reg);
  assign need[1] = !rst && disp_en && (!last_valid_reg[1] || disp_txt_addr != txt_last_reg);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      assign disp_win[gi] = need[gi] && (starve_reg[gi] < STARVE_LIM);
      assign cpu_win[gi]  = cpu_want[gi] && !disp_win[gi];
    end
  endgenerate

`ifdef VRAM_ARB_WBUF_EN
  logic              wbuf_valid_reg, wbuf_sel_reg;
  logic [GFX_AW-1:0] wbuf_addr_reg;
  logic [DW-1:0]     wbuf_data_reg;
  logic              wbuf_load;

  assign wbuf_load = (state_reg == S_IDLE) && cpu_req && cpu_we && !wbuf_valid_reg;

  // ISSUE is never entered while the buffer holds data, so the two never compete.
  always_comb begin
    cpu_want  = 2'b00;
    acc_addr  = cpu_addr;
    acc_we    = cpu_we;
    acc_wdata = cpu_wdata;
    if (wbuf_valid_reg) begin
      cpu_want[wbuf_sel_reg] = !rst;
      acc_addr  = wbuf_addr_reg;
      acc_we    = 1'b1;
      acc_wdata = wbuf_data_reg;
    end else if (state_reg == S_ISSUE) begin
      cpu_want[cpu_sel] = !rst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbuf_valid_reg <= 1'b0;
      wbuf_sel_reg   <= 1'b0;
      wbuf_addr_reg  <= '0;
      wbuf_data_reg  <= '0;
    end else if (wbuf_load) begin
      wbuf_valid_reg <= 1'b1;
      wbuf_sel_reg   <= cpu_sel;
      wbuf_addr_reg  <= cpu_addr;
      wbuf_data_reg  <= cpu_wdata;
    end else if (wbuf_valid_reg && cpu_win[wbuf_sel_reg]) begin
      wbuf_valid_reg <= 1'b0;
    end
  end
`else
  always_comb begin
    cpu_want  = 2'b00;
    acc_addr  = cpu_addr;
    acc_we    = cpu_we;
    acc_wdata = cpu_wdata;
    if (state_reg == S_ISSUE) cpu_want[cpu_sel] = !rst;
  end
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (cpu_req) begin
`ifdef VRAM_ARB_WBUF_EN
          if (!wbuf_valid_reg) state_next = cpu_we ? S_ACK : S_ISSUE;
`else
          state_next = S_ISSUE;
`endif
        end
      end
      S_ISSUE:  if (cpu_win[cpu_sel]) state_next = cpu_we ? S_ACK : S_RDWAIT;
      S_RDWAIT: state_next = S_ACK;
      S_ACK:    state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    gfx_addr  = '0;
    gfx_we    = 1'b0;
    gfx_wdata = '0;
    txt_addr  = '0;
    txt_we    = 1'b0;
    txt_wdata = '0;
    if (disp_win[0]) begin
      gfx_addr = disp_gfx_addr;
    end else if (cpu_win[0]) begin
      gfx_addr  = acc_addr;
      gfx_we    = acc_we;
      gfx_wdata = acc_wdata;
    end
    if (disp_win[1]) begin
      txt_addr = disp_txt_addr;
    end else if (cpu_win[1]) begin
      txt_addr  = acc_addr[TXT_AW-1:0];
      txt_we    = acc_we;
      txt_wdata = acc_wdata;
    end
  end

  assign cpu_ack = !rst && (state_reg == S_ACK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      cpu_rdata      <= '0;
      disp_gfx_data  <= '0;
      disp_txt_data  <= '0;
      fetch_reg      <= 2'b00;
      last_valid_reg <= 2'b00;
      gfx_last_reg   <= '0;
      txt_last_reg   <= '0;
      for (int i = 0; i < 2; i++) starve_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      fetch_reg <= disp_win;
      if (state_reg == S_RDWAIT) cpu_rdata <= cpu_sel ? txt_rdata : gfx_rdata;
      if (fetch_reg[0]) disp_gfx_data <= gfx_rdata;
      if (fetch_reg[1]) disp_txt_data <= txt_rdata;
      // A dropped display fetch leaves the last-address register stale, so it retries.
      if (!disp_en) begin
        last_valid_reg <= 2'b00;
      end else begin
        if (disp_win[0]) begin
          gfx_last_reg      <= disp_gfx_addr;
          last_valid_reg[0] <= 1'b1;
        end
        if (disp_win[1]) begin
          txt_last_reg      <= disp_txt_addr;
          last_valid_reg[1] <= 1'b1;
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (cpu_win[i])       starve_reg[i] <= '0;
        else if (cpu_want[i]) starve_reg[i] <= starve_reg[i] + SW'(1);
      end
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with behavioural 1-cycle-latency models of both video RAMs.
module tb_vram_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        disp_en;
  logic [15:0] disp_gfx_addr;
  logic [9:0]  disp_txt_addr;
  logic [7:0]  disp_gfx_data, disp_txt_data;
  logic        cpu_req, cpu_we, cpu_sel;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [15:0] gfx_addr;
  logic        gfx_we;
  logic [7:0]  gfx_wdata, gfx_rdata;
  logic [9:0]  txt_addr;
  logic        txt_we;
  logic [7:0]  txt_wdata, txt_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] gmem [0:65535];
  logic [7:0] tmem [0:1023];
  int fetch_cnt [0:4095];
  logic prev_cpu_gfx = 1'b0;
  logic retry_seen = 1'b0;

  always #5 clk = ~clk;

  vram_arbiter dut (
    .clk(clk), .rst(rst), .disp_en(disp_en),
    .disp_gfx_addr(disp_gfx_addr), .disp_txt_addr(disp_txt_addr),
    .disp_gfx_data(disp_gfx_data), .disp_txt_data(disp_txt_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_sel(cpu_sel), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .gfx_addr(gfx_addr), .gfx_we(gfx_we), .gfx_wdata(gfx_wdata), .gfx_rdata(gfx_rdata),
    .txt_addr(txt_addr), .txt_we(txt_we), .txt_wdata(txt_wdata), .txt_rdata(txt_rdata)
  );

  always @(posedge clk) begin
    if (gfx_we) gmem[gfx_addr] <= gfx_wdata;
    gfx_rdata <= gmem[gfx_addr];
    if (txt_we) tmem[txt_addr] <= txt_wdata;
    txt_rdata <= tmem[txt_addr];
  end

  // Display fetch log and retry detection after a CPU access to gfx 0x1234.
  always @(negedge clk) begin
    if (!rst && disp_en && !gfx_we && gfx_addr == disp_gfx_addr)
      fetch_cnt[gfx_addr[11:0]] = fetch_cnt[gfx_addr[11:0]] + 1;
    if (prev_cpu_gfx && disp_en && !gfx_we && gfx_addr == disp_gfx_addr) retry_seen = 1'b1;
    prev_cpu_gfx = disp_en && gfx_addr == 16'h1234;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_txn(input logic sel, input logic we, input logic [15:0] addr,
                         input logic [7:0] wdata, output int lat, output logic [7:0] rdata);
    cpu_sel = sel; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    lat = 0;
    rdata = 8'h00;
    do begin
      step();
      lat++;
    end while (!cpu_ack && lat < 40);
    if (!cpu_ack) lat = 999;
    else rdata = cpu_rdata;
    cpu_req = 1'b0;
    step();
  endtask

  initial begin
    int lat;
    int missed;
    logic [7:0] rd;
    for (int i = 0; i < 65536; i++) gmem[i] = i[7:0];
    for (int i = 0; i < 1024; i++) tmem[i] = i[7:0] ^ 8'hA5;
    gfx_rdata = 8'h00; txt_rdata = 8'h00;
    rst = 1'b1; disp_en = 1'b0; disp_gfx_addr = 16'h0; disp_txt_addr = 10'd5;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_sel = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
    step(); step(); step();
    chk("rst_ack", cpu_ack, 0);
    chk("rst_gfx_we", gfx_we, 0);
    rst = 1'b0;
    step();
    chk("rst_disp_gfx", disp_gfx_data, 0);
    chk("rst_disp_txt", disp_txt_data, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_gfx_addr", gfx_addr, 0);
    chk("rst_txt_we", txt_we, 0);

    // Uncontended gfx write 0x1234 = 0x5A, then read back
    cpu_sel = 1'b0; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'h5A; cpu_req = 1'b1;
    step();
`ifdef VRAM_ARB_WBUF_EN
    chk("wb_ack_1clk", cpu_ack, 1);
    chk("wb_drain_we", gfx_we, 1);
    chk("wb_drain_addr", gfx_addr, 16'h1234);
    chk("wb_drain_data", gfx_wdata, 8'h5A);
    cpu_req = 1'b0;
    step();
    chk("wb_we_once", gfx_we, 0);
    chk("wb_ack_once", cpu_ack, 0);
`else
    chk("wr_issue_ack", cpu_ack, 0);
    chk("wr_issue_we", gfx_we, 1);
    chk("wr_issue_addr", gfx_addr, 16'h1234);
    chk("wr_issue_data", gfx_wdata, 8'h5A);
    step();
    chk("wr_ack", cpu_ack, 1);
    chk("wr_we_once", gfx_we, 0);
    cpu_req = 1'b0;
    step();
    chk("wr_ack_once", cpu_ack, 0);
`endif
    cpu_txn(1'b0, 1'b0, 16'h1234, 8'h00, lat, rd);
    chk("rd_lat", lat, 3);
    chk("rd_data", rd, 8'h5A);

    // Scanout every 2 clks: data 2 clks after change, one fetch per address
    disp_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      disp_gfx_addr = 16'h0100 + 16'(k);
      step(); step();
      chk("scan_data", disp_gfx_data, k);
    end
    for (int k = 0; k < 8; k++) chk("scan_fetch_cnt", fetch_cnt[12'h100 + k], 1);
    chk("scan_txt_data", disp_txt_data, 8'hA0);

    // Same scanout with back-to-back CPU gfx writes
    fork
      begin
        for (int k = 0; k < 16; k++) begin
          disp_gfx_addr = 16'h0200 + 16'(k);
          step(); step();
          chk("mix_scan_data", disp_gfx_data, k);
        end
      end
      begin
        int wl;
        logic [7:0] wr;
        for (int j = 0; j < 5; j++) begin
          cpu_txn(1'b0, 1'b1, 16'h8000 + 16'(j), 8'h30 + 8'(j), wl, wr);
          chk("mix_wr_lat_le4", int'(wl <= 4), 1);
        end
      end
    join
    for (int k = 0; k < 16; k++) chk("mix_fetch_cnt", fetch_cnt[12'h200 + k], 1);
    cpu_txn(1'b0, 1'b0, 16'h8004, 8'h00, lat, rd);
    chk("mix_readback", rd, 8'h34);

    // Misused scanout changing every clk: CPU read forced after 2 lost cycles
    fork
      begin
        for (int k = 0; k < 12; k++) begin
          disp_gfx_addr = 16'h0300 + 16'(k);
          step();
        end
      end
      begin
        int sl;
        logic [7:0] sr;
        cpu_txn(1'b0, 1'b0, 16'h1234, 8'h00, sl, sr);
        chk("starve_lat", sl, 5);
        chk("starve_rdata", sr, 8'h5A);
      end
    join
    missed = 0;
    for (int k = 0; k < 12; k++) if (fetch_cnt[12'h300 + k] == 0) missed++;
    chk("starve_missed", missed, 1);
    chk("starve_dropped_addr", fetch_cnt[12'h303], 0);
    chk("starve_retry", retry_seen, 1);

    // Text write to 0x3E7 (upper cpu_addr bits set) while gfx fetches every clk
    disp_gfx_addr = 16'h0400;
    step(); step();
    chk("txt_disp_data", disp_txt_data, 8'hA0);
    fork
      begin
        for (int k = 1; k < 9; k++) begin
          disp_gfx_addr = 16'h0400 + 16'(k);
          step();
        end
      end
      begin
        cpu_sel = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hABE7; cpu_wdata = 8'hC3; cpu_req = 1'b1;
        step();
`ifdef VRAM_ARB_WBUF_EN
        chk("txt_ack", cpu_ack, 1);
`else
        chk("txt_ack_early", cpu_ack, 0);
`endif
        chk("txt_we", txt_we, 1);
        chk("txt_addr", txt_addr, 10'h3E7);
        chk("txt_wdata", txt_wdata, 8'hC3);
`ifndef VRAM_ARB_WBUF_EN
        step();
        chk("txt_ack", cpu_ack, 1);
        chk("txt_we_once", txt_we, 0);
`endif
        cpu_req = 1'b0;
        step();
        chk("txt_ack_once", cpu_ack, 0);
      end
    join
    for (int k = 0; k < 9; k++) chk("txt_gfx_fetch_cnt", fetch_cnt[12'h400 + k], 1);
    cpu_txn(1'b1, 1'b0, 16'h03E7, 8'h00, lat, rd);
    chk("txt_rd_lat", lat, 3);
    chk("txt_readback", rd, 8'hC3);

    // Reset during RDWAIT
    disp_en = 1'b0;
    cpu_sel = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h1234; cpu_req = 1'b1;
    step(); step();
    chk("rdwait_ack", cpu_ack, 0);
    rst = 1'b1;
    step();
    chk("midrst_ack", cpu_ack, 0);
    chk("midrst_gfx_we", gfx_we, 0);
    rst = 1'b0; cpu_req = 1'b0;
    step();
    chk("postrst_ack", cpu_ack, 0);
    chk("postrst_gfx_we", gfx_we, 0);
    chk("postrst_txt_we", txt_we, 0);
    cpu_txn(1'b0, 1'b1, 16'h1235, 8'h77, lat, rd);
`ifdef VRAM_ARB_WBUF_EN
    chk("postrst_wr_lat", lat, 1);
`else
    chk("postrst_wr_lat", lat, 2);
`endif
    cpu_txn(1'b0, 1'b0, 16'h1235, 8'h00, lat, rd);
    chk("postrst_rd_lat", lat, 3);
    chk("postrst_rd_data", rd, 8'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port text RAM (character codes) and gfx RAM (320x200 8-bit pixels) between display scanout and CPU accesses.
- Scanout addresses come from the text/gfx pixel generator. The arbiter fetches only when an address changes: gfx every 2 pixel clocks, text every 16.
- The CPU gets every slot the display does not need, through a req/ack handshake.
- Sits between the VGA pixel pipeline, the CPU bus bridge and the two video RAMs.

Parameters:
- GFX_AW, 16, gfx RAM address width (64000 entries used)
- TXT_AW, 10, text RAM address width (1000 entries used)
- DW, 8, data width of both RAMs and the CPU data bus
- STARVE_MAX, 2, consecutive lost CPU cycles before the CPU is forced to win

Ports:
- clk  in  1  pixel clock; one clock; reset is synchronous and active-high
- rst  in  1  synchronous active-high reset
- disp_en  in  1  screen active (screen_en AND col_en)
- disp_gfx_addr  in  GFX_AW  current scanout pixel address
- disp_txt_addr  in  TXT_AW  current scanout character address
- disp_gfx_data  out  DW  registered pixel for the pipeline
- disp_txt_data  out  DW  registered character code for the pipeline
- cpu_req  in  1  CPU request; held high until cpu_ack
- cpu_we  in  1  1=write, 0=read
- cpu_sel  in  1  0=gfx RAM, 1=text RAM
- cpu_addr  in  GFX_AW  CPU address; low TXT_AW bits used when cpu_sel=1
- cpu_wdata  in  DW  write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DW  read data, valid with cpu_ack
- gfx_addr, gfx_we, gfx_wdata  out  GFX_AW/1/DW  gfx RAM port
- gfx_rdata  in  DW  gfx RAM read data, 1-cycle synchronous latency
- txt_addr, txt_we, txt_wdata  out  TXT_AW/1/DW  text RAM port
- txt_rdata  in  DW  text RAM read data, 1-cycle latency

Behaviour:
- Reset: all outputs 0; last-address registers invalid; CPU FSM in IDLE; starve counters 0.
- A display fetch is needed on a RAM when disp_en=1 AND (last-address register is invalid OR current address != last fetched address). When disp_en=0, both last-address registers are marked invalid.
- Per RAM, each cycle:
  - If a display fetch is needed and that RAM's starve count < STARVE_MAX, the display wins. Drive the display address, we=0, update the last-address register.
  - Otherwise the slot is free.
- disp_*_data loads from *_rdata in the cycle after a display fetch; it holds otherwise.
  - Total latency from address change to new data: 2 clks.
  - Data holds across disp_en=0.
- CPU FSM states:
  - IDLE: on cpu_req, go to ISSUE.
  - ISSUE: when the selected RAM slot is free (or won by starvation), drive the CPU address/we/wdata for one cycle. A write goes to ACK; a read goes to RDWAIT. If the slot is lost, increment that RAM's starve count.
  - RDWAIT: capture *_rdata into cpu_rdata; go to ACK.
  - ACK: cpu_ack=1 for one cycle; go to IDLE. cpu_req may remain high; a new request starts no earlier than the next cycle.
  - Starve count clears on issue.
- Latency with no contention:
  - Write: ack 2 clks after req sampled (IDLE→ISSUE→ACK).
  - Read: ack 3 clks after req sampled.
- Forced CPU win: the display fetch is dropped and is retried next cycle, because the address still differs from the last fetched address.
- A CPU access to one RAM never blocks display fetches on the other RAM.
- cpu_addr bits above TXT_AW are ignored when cpu_sel=1. Addresses are not range-checked.
- rst mid-transaction: returns to IDLE, no ack, no we pulse in the following cycle; the CPU must re-request.

Optional Feature:
- VRAM_ARB_WBUF_EN defined: single-entry posted write buffer.
  - A write in IDLE is acked the cycle after req (buffer captures addr/sel/data).
  - The buffer drains on the next free slot of its RAM.
  - A following CPU request waits in IDLE until the buffer is empty.
  - A read to the buffered address also waits for the drain, so ordering is preserved.
- Not defined: writes are unbuffered as described in Behaviour.

Test Plan:
- Reset, then disp_en=0, CPU write gfx 0x1234=0x5A → gfx_we=1 addr 0x1234 data 0x5A exactly one cycle; cpu_ack 2 clks after req; read back gives cpu_rdata=0x5A at ack (3 clks).
- disp_en=1, gfx addr incrementing every 2 clks from 0, gfx_rdata=addr[7:0] → disp_gfx_data equals each address's low byte 2 clks after the change; exactly one gfx fetch per address.
- Same scanout plus continuous CPU gfx writes → every CPU write completes within 4 clks; no display address is skipped.
- Misused scanout with gfx address changing every clk plus CPU read → the CPU wins after 2 lost cycles (ack ≤ 6 clks); the dropped display fetch is retried the next cycle.
- CPU text write to 0x3E7 while display fetches gfx every cycle → no gfx interference; txt_we in the first ISSUE cycle.
- rst asserted during RDWAIT → no cpu_ack; FSM in IDLE; all we outputs 0 the next cycle. With VRAM_ARB_WBUF_EN, a write is acked 1 clk after req and drains in the first free slot.
